// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the FSM state encoding, the bit positions of the store and load
// select vectors, and a helper that isolates the lowest set bit of a pick.
package mem_access_ctrl_pkg;

  // Controller states: idle, bus address phase, waiting for read data, retire.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bit positions inside mem_wen_pick.
  localparam int PICK_SW  = 0;
  localparam int PICK_SH  = 1;
  localparam int PICK_SB  = 2;
  localparam int PICK_SWL = 3;
  localparam int PICK_SWR = 4;

  // Bit positions inside ld_pick.
  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LWL = 4;
  localparam int LD_LWR = 5;
  localparam int LD_LW  = 6;

  // Keeps only the lowest set bit, so a malformed pick still decodes to one op.
  function automatic logic [6:0] lowest_set(input logic [6:0] v);
    return v & (~v + 7'd1);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// mem_align: purely combinational lane steering for the memory controller.
// Store mode (is_load=0): turns a store pick, the byte offset and the rt
// value into byte strobes and lane-aligned write data.
// Load mode (is_load=1): turns a load pick, the byte offset and the bus
// word into an extended/shifted result plus a byte mask telling which
// result bytes come from memory; bytes outside the mask keep rt (LWL/LWR).
module mem_align
  import mem_access_ctrl_pkg::*;
(
  input  logic        is_load,
  input  logic [6:0]  pick,
  input  logic [1:0]  a,
  input  logic [31:0] din,
  output logic [3:0]  strb,
  output logic [31:0] dout
);

  logic [31:0] din_shr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte and halfword picked out of the word by the low address bits.
  always_comb begin
    din_shr  = din >> {a, 3'b000};
    byte_sel = din_shr[7:0];
    half_sel = a[1] ? din[31:16] : din[15:0];
  end

  // Lane steering for either direction; picks arrive already one-hot.
  always_comb begin
    strb = 4'b0000;
    dout = 32'h0;
    if (is_load) begin
      strb = 4'b1111;
      dout = din;
      if (pick[LD_LB]) begin
        dout = {{24{byte_sel[7]}}, byte_sel};
      end else if (pick[LD_LBU]) begin
        dout = {24'h0, byte_sel};
      end else if (pick[LD_LH]) begin
        dout = {{16{half_sel[15]}}, half_sel};
      end else if (pick[LD_LHU]) begin
        dout = {16'h0, half_sel};
      end else if (pick[LD_LWL]) begin
        dout = din << {~a, 3'b000};
        strb = 4'b1111 << ~a;
      end else if (pick[LD_LWR]) begin
        dout = din_shr;
        strb = 4'b1111 >> a;
      end
    end else begin
      if (pick[PICK_SW]) begin
        strb = 4'b1111;
        dout = din;
      end else if (pick[PICK_SH]) begin
        strb = a[1] ? 4'b1100 : 4'b0011;
        dout = {2{din[15:0]}};
      end else if (pick[PICK_SB]) begin
        strb = 4'b0001 << a;
        dout = {4{din[7:0]}};
      end else if (pick[PICK_SWL]) begin
        strb = 4'b1111 >> ~a;
        dout = din >> {~a, 3'b000};
      end else if (pick[PICK_SWR]) begin
        strb = 4'b1111 << a;
        dout = din << {a, 3'b000};
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences pipeline loads/stores onto the single-port
// data-memory bus with a request/grant/read-valid handshake and stalls the
// pipeline until the access retires.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned word/halfword accesses skip
// the bus and retire at once with addr_err set; without it the low address
// bits that do not matter for the access size are ignored.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic [4:0]        mem_wen_pick,
  input  logic [6:0]        ld_pick,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       rt_old,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              stall,
  output logic              addr_err
);

  state_t            state_q, state_d;
  logic              bus_wr_q, bus_wr_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [6:0]        ld_pick_q, ld_pick_d;
  logic [1:0]        a_q, a_d;
  logic [31:0]       rt_q, rt_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              err_q, err_d;

  logic              is_store;
  logic              accept;
  logic              misalign;
  logic [6:0]        st_sel;
  logic [6:0]        ld_sel;
  logic [3:0]        st_strb;
  logic [31:0]       st_wdata;
  logic [3:0]        ld_mask;
  logic [31:0]       ld_data;
  logic [31:0]       ld_mask32;
  logic [31:0]       ld_merged;

  // A store pick outranks mem_read; within each vector the lowest bit wins.
  assign is_store = |mem_wen_pick;
  assign accept   = (state_q == ST_IDLE) && req_valid && (mem_read || is_store);
  assign st_sel   = lowest_set({2'b00, mem_wen_pick});
  assign ld_sel   = is_store ? 7'h00 : lowest_set(ld_pick);

`ifdef MEM_ALIGN_CHECK_EN
  // Word accesses need a=0, halfword accesses need a[0]=0.
  assign misalign = (st_sel[PICK_SW] && (addr[1:0] != 2'b00)) ||
                    (st_sel[PICK_SH] && addr[0]) ||
                    (ld_sel[LD_LW] && (addr[1:0] != 2'b00)) ||
                    ((ld_sel[LD_LH] || ld_sel[LD_LHU]) && addr[0]);
`else
  assign misalign = 1'b0;
`endif

  // Store lanes are computed from the live request and captured at accept.
  mem_align u_store_align (
    .is_load (1'b0),
    .pick    (st_sel),
    .a       (addr[1:0]),
    .din     (store_data),
    .strb    (st_strb),
    .dout    (st_wdata)
  );

  // Load extraction works on the returned word and the captured op.
  mem_align u_load_align (
    .is_load (1'b1),
    .pick    (ld_pick_q),
    .a       (a_q),
    .din     (bus_rdata),
    .strb    (ld_mask),
    .dout    (ld_data)
  );

  // Bytes outside the load mask keep the old rt value (LWL/LWR merge).
  always_comb begin
    ld_mask32 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ld_mask32[8*i +: 8] = {8{ld_mask[i]}};
    end
    ld_merged = (ld_data & ld_mask32) | (rt_q & ~ld_mask32);
  end

  // State register plus captured op and bus fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'h0;
      ld_pick_q   <= 7'h00;
      a_q         <= 2'b00;
      rt_q        <= 32'h0;
      resp_data_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      ld_pick_q   <= ld_pick_d;
      a_q         <= a_d;
      rt_q        <= rt_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: misaligned ops bypass the bus, stores skip RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = misalign ? ST_DONE : ST_REQ;
      ST_REQ:  if (bus_gnt) state_d = bus_wr_q ? ST_DONE : ST_RESP;
      ST_RESP: if (bus_rvalid) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath capture: bus fields frozen from accept until the next accept.
  always_comb begin
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    ld_pick_d   = ld_pick_q;
    a_d         = a_q;
    rt_d        = rt_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    if (accept) begin
      bus_wr_d    = is_store;
      bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
      bus_wstrb_d = st_strb;
      bus_wdata_d = st_wdata;
      ld_pick_d   = ld_sel;
      a_d         = addr[1:0];
      rt_d        = rt_old;
      resp_data_d = 32'h0;
      err_d       = misalign;
    end else if ((state_q == ST_RESP) && bus_rvalid) begin
      resp_data_d = ld_merged;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    bus_req    = (state_q == ST_REQ);
    stall      = (state_q == ST_REQ) || (state_q == ST_RESP);
    resp_valid = (state_q == ST_DONE);
    addr_err   = (state_q == ST_DONE) && err_q;
    bus_wr     = bus_wr_q;
    bus_addr   = bus_addr_q;
    bus_wstrb  = bus_wstrb_q;
    bus_wdata  = bus_wdata_q;
    resp_data  = resp_data_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. The bench plays the memory bus,
// drives directed and random loads/stores, and compares every observed
// output against a byte-level reference model of the load/store rules.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic [4:0]  mem_wen_pick;
  logic [6:0]  ld_pick;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] rt_old;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        stall;
  logic        addr_err;

  int testCount = 0;
  int failCount = 0;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .mem_read     (mem_read),
    .mem_wen_pick (mem_wen_pick),
    .ld_pick      (ld_pick),
    .addr         (addr),
    .store_data   (store_data),
    .rt_old       (rt_old),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .stall        (stall),
    .addr_err     (addr_err)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Index of the lowest set bit, -1 if none.
  function automatic int lowestIdx(input logic [6:0] v);
    for (int i = 0; i < 7; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: decides the op and derives strobes, write data, the
  // load result and the alignment error from byte-level rules.
  function automatic void modelOp(
    input  logic [4:0]  wp,
    input  logic [6:0]  lp,
    input  logic [31:0] ad,
    input  logic [31:0] sd,
    input  logic [31:0] rt,
    input  logic [31:0] w,
    output logic        expWr,
    output logic [3:0]  expStrb,
    output logic [31:0] expWdata,
    output logic [31:0] expResp,
    output logic        expErr
  );
    int si;
    int li;
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    si = lowestIdx({2'b00, wp});
    li = lowestIdx(lp);
    a = int'(ad[1:0]);
    expWr = (si >= 0);
    expStrb = 4'b0000;
    expWdata = 32'h0;
    expResp = 32'h0;
    expErr = 1'b0;
    if (expWr) begin
      for (int i = 0; i < 4; i++) begin
        case (si)
          0: expStrb[i] = 1'b1;
          1: expStrb[i] = ((i / 2) == (a / 2));
          2: expStrb[i] = (i == a);
          3: expStrb[i] = (i <= a);
          default: expStrb[i] = (i >= a);
        endcase
      end
      case (si)
        0: expWdata = sd;
        1: expWdata = {sd[15:0], sd[15:0]};
        2: expWdata = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
        3: expWdata = sd >> (8 * (3 - a));
        default: expWdata = sd << (8 * a);
      endcase
`ifdef MEM_ALIGN_CHECK_EN
      expErr = ((si == 0) && (a != 0)) || ((si == 1) && (a % 2 == 1));
`endif
    end else begin
      b = w[8*a +: 8];
      h = (a >= 2) ? w[31:16] : w[15:0];
      case (li)
        0: expResp = {{24{b[7]}}, b};
        1: expResp = {24'h0, b};
        2: expResp = {{16{h[15]}}, h};
        3: expResp = {16'h0, h};
        4: begin
          for (int j = 0; j < 4; j++) begin
            expResp[8*j +: 8] = (j >= 3 - a) ? w[8*(j-(3-a)) +: 8] : rt[8*j +: 8];
          end
        end
        5: begin
          for (int j = 0; j < 4; j++) begin
            expResp[8*j +: 8] = (j <= 3 - a) ? w[8*(j+a) +: 8] : rt[8*j +: 8];
          end
        end
        default: expResp = w;
      endcase
`ifdef MEM_ALIGN_CHECK_EN
      expErr = ((li == 6) && (a != 0)) || (((li == 2) || (li == 3)) && (a % 2 == 1));
`endif
      if (expErr) expResp = 32'h0;
    end
  endfunction

  // Issues one op from IDLE, acts as the bus with the given grant and
  // read-valid delays, and checks every cycle up to the retire pulse.
  task automatic applyStimulus(
    input logic        rd,
    input logic [4:0]  wp,
    input logic [6:0]  lp,
    input logic [31:0] ad,
    input logic [31:0] sd,
    input logic [31:0] rt,
    input logic [31:0] rdata,
    input int          gntDly,
    input int          rvDly,
    input logic        earlyRv
  );
    logic        expWr;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expResp;
    logic        expErr;
    modelOp(wp, lp, ad, sd, rt, rdata, expWr, expStrb, expWdata, expResp, expErr);

    @(negedge clk);
    checkOutput("idle_req_ready", req_ready, 1);
    checkOutput("idle_resp_valid", resp_valid, 0);
    req_valid = 1'b1;
    mem_read = rd;
    mem_wen_pick = wp;
    ld_pick = lp;
    addr = ad;
    store_data = sd;
    rt_old = rt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_read = 1'($urandom_range(0, 1));
    mem_wen_pick = 5'($urandom);
    ld_pick = 7'($urandom);
    addr = $urandom;
    store_data = $urandom;
    rt_old = $urandom;

    if (expErr) begin
      @(negedge clk);
      checkOutput("err_resp_valid", resp_valid, 1);
      checkOutput("err_addr_err", addr_err, 1);
      checkOutput("err_resp_data", resp_data, 0);
      checkOutput("err_bus_req", bus_req, 0);
      checkOutput("err_stall", stall, 0);
      return;
    end

    for (int c = 0; c <= gntDly; c++) begin
      @(negedge clk);
      checkOutput("req_bus_req", bus_req, 1);
      checkOutput("req_stall", stall, 1);
      checkOutput("req_ready_low", req_ready, 0);
      checkOutput("req_resp_valid", resp_valid, 0);
      checkOutput("req_bus_wr", bus_wr, expWr);
      checkOutput("req_bus_addr", bus_addr, {ad[31:2], 2'b00});
      if (expWr) begin
        checkOutput("req_bus_wstrb", bus_wstrb, expStrb);
        checkOutput("req_bus_wdata", bus_wdata, expWdata);
      end
      bus_gnt = (c == gntDly);
      bus_rvalid = (c == gntDly) && earlyRv && !expWr;
      bus_rdata = ~rdata;
    end
    @(posedge clk);
    #1;
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;

    if (!expWr) begin
      for (int c = 0; c <= rvDly; c++) begin
        @(negedge clk);
        checkOutput("resp_bus_req", bus_req, 0);
        checkOutput("resp_stall", stall, 1);
        checkOutput("resp_resp_valid", resp_valid, 0);
        bus_rvalid = (c == rvDly);
        bus_rdata = (c == rvDly) ? rdata : $urandom;
      end
      @(posedge clk);
      #1;
      bus_rvalid = 1'b0;
    end

    @(negedge clk);
    checkOutput("done_resp_valid", resp_valid, 1);
    checkOutput("done_resp_data", resp_data, expResp);
    checkOutput("done_addr_err", addr_err, 0);
    checkOutput("done_stall", stall, 0);
    checkOutput("done_bus_req", bus_req, 0);
  endtask

  // Resets the controller while it sits in REQ, then again while in RESP,
  // and confirms a late rvalid produces no retire pulse.
  task automatic resetMidOp();
    @(negedge clk);
    req_valid = 1'b1;
    mem_read = 1'b1;
    mem_wen_pick = 5'b00000;
    ld_pick = 7'b1000000;
    addr = 32'h0000_0040;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_bus_req_before", bus_req, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_req_bus_req_after", bus_req, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    checkOutput("rst_resp_stall_before", stall, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_resp_stall_after", stall, 0);
    checkOutput("rst_resp_bus_req", bus_req, 0);
    checkOutput("rst_resp_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rst_late_rvalid_resp_valid", resp_valid, 0);
      checkOutput("rst_late_rvalid_ready", req_ready, 1);
    end
  endtask

  // Main sequence: reset values, directed cases, random ops, reset mid-op.
  initial begin
    logic        rd;
    logic [4:0]  wp;
    logic [6:0]  lp;
    rst = 1'b1;
    req_valid = 1'b0;
    mem_read = 1'b0;
    mem_wen_pick = 5'b00000;
    ld_pick = 7'b0000000;
    addr = 32'h0;
    store_data = 32'h0;
    rt_old = 32'h0;
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = 32'h0;

    @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_bus_req", bus_req, 0);
    checkOutput("reset_bus_wr", bus_wr, 0);
    checkOutput("reset_bus_addr", bus_addr, 0);
    checkOutput("reset_bus_wstrb", bus_wstrb, 0);
    checkOutput("reset_bus_wdata", bus_wdata, 0);
    checkOutput("reset_resp_valid", resp_valid, 0);
    checkOutput("reset_resp_data", resp_data, 0);
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_addr_err", addr_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // req_valid without any memory op must be ignored.
    @(negedge clk);
    req_valid = 1'b1;
    mem_read = 1'b0;
    mem_wen_pick = 5'b00000;
    ld_pick = 7'b1000000;
    @(negedge clk);
    checkOutput("noop_req_ready", req_ready, 1);
    checkOutput("noop_bus_req", bus_req, 0);
    checkOutput("noop_stall", stall, 0);
    req_valid = 1'b0;

    // Directed cases.
    applyStimulus(1'b0, 5'b00100, 7'h00, 32'h0000_1003, 32'h0000_00AB, 32'h0, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b1, 5'b00000, 7'b0000001, 32'h0000_2001, 32'h0, 32'h0, 32'h1234_80FF, 0, 0, 1'b0);
    applyStimulus(1'b1, 5'b00000, 7'b0000010, 32'h0000_2001, 32'h0, 32'h0, 32'h1234_80FF, 0, 0, 1'b0);
    applyStimulus(1'b1, 5'b00000, 7'b0010000, 32'h0000_4001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 1'b0);
    applyStimulus(1'b1, 5'b00000, 7'b0100000, 32'h0000_4002, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 1'b0);
    applyStimulus(1'b1, 5'b00000, 7'b1000000, 32'h0000_5000, 32'h0, 32'h0, 32'hCAFE_F00D, 5, 2, 1'b1);
    applyStimulus(1'b1, 5'b00000, 7'b1000000, 32'h0000_3002, 32'h0, 32'h0, 32'h0BAD_0BAD, 0, 0, 1'b0);
    applyStimulus(1'b1, 5'b00001, 7'b1000000, 32'h0000_6001, 32'h8765_4321, 32'h0, 32'h0, 1, 0, 1'b0);

    // Random ops, including non-one-hot picks and store-over-load conflicts.
    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1: wp = 5'b00000;
        2: wp = 5'(1 << $urandom_range(0, 4));
        default: wp = 5'($urandom);
      endcase
      if (wp == 5'b00000) rd = 1'b1;
      lp = 7'(1 << $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) lp = lp | 7'($urandom);
      applyStimulus(rd, wp, lp, $urandom, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
    end

    resetMidOp();

    // One op after the mid-operation reset to show the controller recovered.
    applyStimulus(1'b1, 5'b00000, 7'b0000100, 32'h0000_7002, 32'h0, 32'h0, 32'h8001_7FFF, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences every load/store issued by the decode/execute pipeline onto the single-port data-memory bus. It consumes the decoded memory-op selects (store picks, load kind), generates the byte strobes and aligned write data, and runs a request/grant/read-valid handshake. It then merges returned data, including LWL/LWR with the old rt value, and stalls the pipeline until the access retires.

## Interface
- ADDR_W, 32, address width; the data path is fixed at 32 bits.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  pipeline presents a memory op this cycle.
- req_ready  out  1  high only in IDLE.
- mem_read  in  1  op is a load.
- mem_wen_pick  in  5  one-hot store select: [0] sw, [1] sh, [2] sb, [3] swl, [4] swr.
- ld_pick  in  7  one-hot load select: [0] lb, [1] lbu, [2] lh, [3] lhu, [4] lwl, [5] lwr, [6] lw. Wired from reg_write_src[13:7].
- addr  in  ADDR_W  effective byte address.
- store_data  in  32  rt value for stores.
- rt_old  in  32  rt value for the LWL/LWR merge.
- bus_req  out  1  bus request.
- bus_wr  out  1  1 = write.
- bus_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2], 2'b00}.
- bus_wstrb  out  4  byte strobes.
- bus_wdata  out  32  lane-aligned write data.
- bus_gnt  in  1  address phase accepted.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read word.
- resp_valid  out  1  one-cycle retire pulse.
- resp_data  out  32  aligned/merged load result; 0 for stores.
- stall  out  1  freeze upstream pipeline.
- addr_err  out  1  misaligned access; valid with resp_valid.

## Operation
FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - Accepts a transfer when req_valid && (mem_read || |mem_wen_pick).
  - Latches the op, addr, store_data and rt_old, then goes to REQ.
  - req_valid with no memory op is ignored and the FSM stays in IDLE.
- **Select priority**
  - If both a store pick and mem_read are set, the store wins.
  - If a pick vector is not one-hot, the lowest set bit wins.
- **REQ**
  - bus_req=1; bus_wr/addr/wstrb/wdata are held stable until bus_gnt.
  - On gnt, a store goes to DONE and a load goes to RESP.
- **RESP**
  - Waits for bus_rvalid, registers the merged result into resp_data, then goes to DONE.
  - bus_rvalid is sampled only in RESP.
- **DONE**
  - resp_valid=1 for exactly one cycle, then the FSM returns to IDLE.
- **stall** = state is REQ or RESP.
- **Store lanes** (a = addr[1:0], little-endian):
  - sw: strobe 1111, data sd.
  - sh: strobe a[1] ? 1100 : 0011, data {2{sd[15:0]}}.
  - sb: strobe 0001<<a, data {4{sd[7:0]}}.
  - swl, a=0..3: strobes 0001/0011/0111/1111, data sd>>24/sd>>16/sd>>8/sd.
  - swr, a=0..3: strobes 1111/1110/1100/1000, data sd/sd<<8/sd<<16/sd<<24.
- **Loads** (w = bus_rdata):
  - lb/lbu: byte a, sign- or zero-extended.
  - lh/lhu: halfword a[1], sign- or zero-extended.
  - lw: w.
  - lwl, a=0..3: {w[7:0],rt[23:0]}, {w[15:0],rt[15:0]}, {w[23:0],rt[7:0]}, w.
  - lwr, a=0..3: w, {rt[31:24],w[31:8]}, {rt[31:16],w[31:16]}, {rt[31:8],w[31:24]}.

## Timing
- **Reset values:** state IDLE, req_ready 1, every other output 0.
- **Reset mid-operation:** reset drops bus_req asynchronously, and any later rvalid is ignored.
- **Accept:** a transfer accepted at edge T raises bus_req from T+1; the outputs are registered.
- **Minimum latency:**
  - Store: gnt in cycle T+1, resp_valid in T+2.
  - Load: gnt in T+1, rvalid in T+2, resp_valid in T+3.
- **Back-to-back:** the next op is accepted in the cycle after DONE, so the minimum is 3 cycles per store and 4 per load.
- **Early rvalid:** rvalid asserted in the same cycle as gnt is ignored; the bus returns data at least one cycle after gnt.
- **Bus stalls:** gnt and rvalid may be delayed indefinitely; the FSM holds state and stall stays 1.

## Configuration
- **MEM_ALIGN_CHECK_EN defined:**
  - A misaligned access is lw/sw with a≠0, or lh/lhu/sh with a[0]=1.
  - Such an access skips the bus and goes IDLE→DONE: resp_valid=1, addr_err=1, resp_data=0, bus_req never rises.
- **Not defined:**
  - addr_err is tied to 0.
  - Unused low address bits are ignored: lw/sw use the word, lh/sh use a[1].

## Structure
- **Constants in define.v:** FSM state encodings, mem_wen_pick bit indices (SW/SH/SB/SWL/SWR), and ld_pick bit indices.
- **Sub-module mem_align:** purely combinational. Produces the store strobe and data from (pick, a, sd), and the load extract/merge from (pick, a, w, rt_old). It is instantiated once for the store path and once for the load path.
- The FSM and registers live in mem_access_ctrl.

## Test plan
- **sb:** addr=0x1003, sd=0x000000AB, gnt at first REQ cycle → bus_addr=0x1000, wstrb=1000, wdata=0xABABABAB, resp_valid at T+2.
- **lb, sign extension:** addr=0x2001, rdata=0x1234_80FF → resp_data=0xFFFFFF80; the same case with lbu → 0x00000080.
- **lwl/lwr merge:** rdata=0xAABBCCDD, rt_old=0x11223344.
  - lwl, a=1 → 0xCCDD3344.
  - lwr, a=2 → 0x1122AABB.
- **Bus back-pressure:** gnt held low for 5 cycles, then rvalid 3 cycles after gnt → bus fields stable throughout, stall=1 until DONE, exactly one resp_valid pulse.
- **Reset mid-load:** assert rst in RESP → bus_req=0 immediately, state IDLE; an rvalid after reset release produces no resp_valid.
- **Misaligned lw:** addr=0x3002.
  - With MEM_ALIGN_CHECK_EN: addr_err=1, no bus_req.
  - Without it: bus_addr=0x3000, a normal load.
